// File: rtl/pixel_unpack_pkg.sv
// Shared types and helpers for the FWFT FIFO pixel unpacker.
//   unpack_state_t  : burst controller states
//   slots_per_word  : number of pixels carried by one FIFO word
package pixel_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } unpack_state_t;

  function automatic int slots_per_word(input int word_bits, input int pixel_bits);
    return word_bits / pixel_bits;
  endfunction

endpackage

// File: rtl/fifo_pixel_unpacker.sv
// Read-side consumer for a first-word-fall-through FIFO. Pops packed words and
// replays them as PIXEL_BITS-wide pixels on a valid/ready stream, one burst of
// pix_count pixels per start. Keeps one pixel per clock across word boundaries
// when the FIFO and the sink keep up.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start, pix_count burst request and pixel count (sampled only while idle)
//   fifo_not_empty   FIFO head word valid
//   fifo_data        FIFO head word
//   shift_out        combinational pop of the FIFO head
//   pix_out          current pixel
//   pix_valid        pix_out valid
//   pix_ready        sink accepts pix_out
//   busy             burst in progress
//   done             one-cycle pulse at burst end
module fifo_pixel_unpacker
  import pixel_unpack_pkg::*;
#(
  parameter int WORD_BITS  = 16,
  parameter int PIXEL_BITS = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_BITS-1:0]   pix_count,
  input  logic                  fifo_not_empty,
  input  logic [WORD_BITS-1:0]  fifo_data,
  output logic                  shift_out,
  output logic [PIXEL_BITS-1:0] pix_out,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int SLOTS  = slots_per_word(WORD_BITS, PIXEL_BITS);
  localparam int SLOT_W = $clog2(SLOTS) + 1;
  localparam logic [SLOT_W-1:0]   SLOTS_V = SLOT_W'(SLOTS);
  localparam logic [SLOT_W-1:0]   SLOT_ONE = SLOT_W'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  generate
    if (WORD_BITS % PIXEL_BITS != 0) begin : g_bad_widths
      $error("fifo_pixel_unpacker: WORD_BITS must be a multiple of PIXEL_BITS");
    end
  endgenerate

  unpack_state_t          state_q, state_d;
  logic [CNT_BITS-1:0]    remaining_q, remaining_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   shift_c;
  logic [WORD_BITS-1:0]   shreg_adv;

  // The pixel on offer always sits at the head of the shift register; each
  // accept moves the word one pixel toward that head.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign pix_out   = shreg_q[WORD_BITS-1 -: PIXEL_BITS];
      assign shreg_adv = shreg_q << PIXEL_BITS;
    end else begin : g_lsb_first
      assign pix_out   = shreg_q[PIXEL_BITS-1:0];
      assign shreg_adv = shreg_q >> PIXEL_BITS;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    slot_d      = slot_q;
    shreg_d     = shreg_q;
    pix_valid_d = pix_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shift_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (pix_count != '0) begin
            remaining_d = pix_count;
            busy_d      = 1'b1;
            state_d     = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        shift_c = fifo_not_empty;
        if (fifo_not_empty) begin
          shreg_d     = fifo_data;
          slot_d      = SLOTS_V;
          pix_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (pix_valid_q && pix_ready) begin
          remaining_d = remaining_q - CNT_ONE;
          slot_d      = slot_q - SLOT_ONE;
          shreg_d     = shreg_adv;
          if (remaining_q == CNT_ONE) begin
            // Leftover slots of the current word are simply dropped.
            pix_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (slot_q == SLOT_ONE) begin
            // Pop the next word on the last accept so there is no bubble.
            shift_c = fifo_not_empty;
            if (fifo_not_empty) begin
              shreg_d = fifo_data;
              slot_d  = SLOTS_V;
            end else begin
              pix_valid_d = 1'b0;
              state_d     = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The pop strobe is combinational, so it must be forced low during reset.
  assign shift_out = shift_c & ~reset;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      slot_q      <= '0;
      shreg_q     <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      slot_q      <= slot_d;
      shreg_q     <= shreg_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Bench for fifo_pixel_unpacker: one MSB-first and one LSB-first instance share
// a 2-word FWFT FIFO model; sel picks which one is exercised.
module tb_fifo_pixel_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pix_count = '0;
  logic        pix_ready = 1'b0;
  logic        sel = 1'b0;
  logic        fifo_not_empty = 1'b0;
  logic [15:0] fifo_data = '0;
  logic        push_en = 1'b0;
  logic [15:0] push_word = '0;
  logic        flush_req = 1'b0;
  logic        auto_fill = 1'b0;

  logic       shift_out_m, pix_valid_m, busy_m, done_m;
  logic       shift_out_l, pix_valid_l, busy_l, done_l;
  logic [3:0] pix_out_m, pix_out_l;
  logic       start_m, start_l;
  logic       shift_out_s, pix_valid_s, busy_s, done_s;
  logic [3:0] pix_out_s;

  assign start_m     = start & ~sel;
  assign start_l     = start & sel;
  assign shift_out_s = sel ? shift_out_l : shift_out_m;
  assign pix_valid_s = sel ? pix_valid_l : pix_valid_m;
  assign busy_s      = sel ? busy_l : busy_m;
  assign done_s      = sel ? done_l : done_m;
  assign pix_out_s   = sel ? pix_out_l : pix_out_m;

  fifo_pixel_unpacker #(.WORD_BITS(16), .PIXEL_BITS(4), .MSB_FIRST(1'b1), .CNT_BITS(16)) dut_msb (
    .clk(clk), .reset(reset), .start(start_m), .pix_count(pix_count),
    .fifo_not_empty(fifo_not_empty), .fifo_data(fifo_data), .shift_out(shift_out_m),
    .pix_out(pix_out_m), .pix_valid(pix_valid_m), .pix_ready(pix_ready & ~sel),
    .busy(busy_m), .done(done_m)
  );

  fifo_pixel_unpacker #(.WORD_BITS(16), .PIXEL_BITS(4), .MSB_FIRST(1'b0), .CNT_BITS(16)) dut_lsb (
    .clk(clk), .reset(reset), .start(start_l), .pix_count(pix_count),
    .fifo_not_empty(fifo_not_empty), .fifo_data(fifo_data), .shift_out(shift_out_l),
    .pix_out(pix_out_l), .pix_valid(pix_valid_l), .pix_ready(pix_ready & sel),
    .busy(busy_l), .done(done_l)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- FIFO model (2 words, first-word-fall-through) ----------
  logic [15:0] fq[$];
  logic [15:0] hist[$];   // every word ever written, in FIFO order
  int          head_idx = 0;   // words removed so far (pops + flushes)
  int          pops = 0;
  logic        pop_pend = 1'b0;

  always @(posedge clk) begin
    logic [15:0] w;
    if (pop_pend && fq.size() > 0) begin
      void'(fq.pop_front());
      head_idx++;
      pops++;
    end
    if (flush_req) begin
      while (fq.size() > 0) begin
        void'(fq.pop_front());
        head_idx++;
      end
    end
    if (push_en && fq.size() < 2) begin
      fq.push_back(push_word);
      hist.push_back(push_word);
    end
    if (auto_fill) begin
      while (fq.size() < 2) begin
        w = 16'($urandom);
        fq.push_back(w);
        hist.push_back(w);
      end
    end
    fifo_not_empty <= (fq.size() != 0);
    fifo_data      <= (fq.size() != 0) ? fq[0] : 16'h0000;
  end

  // ---------------- monitor (samples on the falling edge) ------------------
  int         cyc = 0;
  logic [3:0] got_pix[$];
  int         acc_cyc[$];
  int         so_cyc[$];
  int         done_cyc[$];
  logic [3:0] stall_pix[$];
  int         stall_so = 0;
  int         busy_cnt = 0;
  int         so_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pop_pend <= shift_out_s;
    if (shift_out_s && !fifo_not_empty) so_viol++;
    if (shift_out_s) so_cyc.push_back(cyc);
    if (pix_valid_s && pix_ready) begin
      got_pix.push_back(pix_out_s);
      acc_cyc.push_back(cyc);
    end
    if (done_s) done_cyc.push_back(cyc);
    if (busy_s) busy_cnt++;
    if (pix_valid_s && !pix_ready) begin
      stall_pix.push_back(pix_out_s);
      if (shift_out_s) stall_so++;
    end
  end

  // ---------------- reference model ----------------------------------------
  // Pixel i of a burst starting at FIFO word index base, in emission order.
  function automatic logic [3:0] exp_pix(input int base, input int i, input bit lsb);
    logic [15:0] w;
    int s;
    w = hist[base + i / 4];
    s = i % 4;
    if (lsb) return w[4*s +: 4];
    return w[12 - 4*s +: 4];
  endfunction

  // ---------------- stimulus helpers (no checks inside) --------------------
  int b_base, b_pix0, b_acc0, b_so0, b_done0, b_pops0, b_busy0, b_stall0, b_stall_so0, b_start_cyc;
  bit b_timeout;

  task automatic snapshot();
    b_base = head_idx; b_pix0 = got_pix.size(); b_acc0 = acc_cyc.size();
    b_so0 = so_cyc.size(); b_done0 = done_cyc.size(); b_pops0 = pops;
    b_busy0 = busy_cnt; b_stall0 = stall_pix.size(); b_stall_so0 = stall_so;
    b_start_cyc = cyc;
  endtask

  task automatic push(input logic [15:0] w);
    @(posedge clk); #1;
    push_en = 1'b1; push_word = w;
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic flush();
    @(posedge clk); #1; flush_req = 1'b1;
    @(posedge clk); #1; flush_req = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles after 2 accepts
  task automatic run_burst(input int n, input int mode);
    int stall_n;
    stall_n = 0;
    @(posedge clk); #1;
    snapshot();
    start = 1'b1; pix_count = 16'(n);
    pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b_timeout = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (done_cyc.size() > b_done0) begin
        b_timeout = 1'b0;
        break;
      end
      if (mode == 1) pix_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && (got_pix.size() - b_pix0) >= 2 && stall_n < 3) begin
        pix_ready = 1'b0;
        stall_n++;
      end else pix_ready = 1'b1;
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({shift_out_m, pix_valid_m, busy_m, done_m, pix_out_m} !== 8'h00) begin
      failures++; $display("FAIL reset_msb outputs got=%h want=00", {shift_out_m, pix_valid_m, busy_m, done_m, pix_out_m});
    end
    checks++;
    if ({shift_out_l, pix_valid_l, busy_l, done_l, pix_out_l} !== 8'h00) begin
      failures++; $display("FAIL reset_lsb outputs got=%h want=00", {shift_out_l, pix_valid_l, busy_l, done_l, pix_out_l});
    end
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_single_word();
    push(16'hABCD);
    run_burst(4, 0);
    checks++;
    if (b_timeout || got_pix.size() - b_pix0 != 4) begin
      failures++; $display("FAIL single_word count got=%0d want=4 timeout=%0d", got_pix.size() - b_pix0, b_timeout);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_pix[b_pix0 + i] !== exp_pix(b_base, i, 1'b0)) begin
          failures++; $display("FAIL single_word pix%0d got=%h want=%h", i, got_pix[b_pix0 + i], exp_pix(b_base, i, 1'b0));
        end
      end
      checks++;
      if (acc_cyc[b_acc0 + 3] - acc_cyc[b_acc0] != 3) begin
        failures++; $display("FAIL single_word contiguous span got=%0d want=3", acc_cyc[b_acc0 + 3] - acc_cyc[b_acc0]);
      end
    end
    checks++;
    if (pops - b_pops0 != 1) begin failures++; $display("FAIL single_word pops got=%0d want=1", pops - b_pops0); end
    checks++;
    if (done_cyc.size() - b_done0 != 1 || busy_s !== 1'b0) begin
      failures++; $display("FAIL single_word done/busy got done=%0d busy=%b want done=1 busy=0", done_cyc.size() - b_done0, busy_s);
    end
    $display("test_single_word: burst of 4, pixels=%0d", got_pix.size() - b_pix0);
  endtask

  task automatic test_word_boundary();
    push(16'h1234);
    push(16'h5678);
    run_burst(6, 0);
    checks++;
    if (b_timeout || got_pix.size() - b_pix0 != 6) begin
      failures++; $display("FAIL boundary count got=%0d want=6", got_pix.size() - b_pix0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_pix[b_pix0 + i] !== 4'(i + 1)) begin
          failures++; $display("FAIL boundary pix%0d got=%h want=%h", i, got_pix[b_pix0 + i], 4'(i + 1));
        end
      end
      checks++;
      if (acc_cyc[b_acc0 + 5] - acc_cyc[b_acc0] != 5) begin
        failures++; $display("FAIL boundary gap span got=%0d want=5", acc_cyc[b_acc0 + 5] - acc_cyc[b_acc0]);
      end
    end
    checks++;
    if (pops - b_pops0 != 2 || fifo_not_empty !== 1'b0) begin
      failures++; $display("FAIL boundary pops got=%0d ne=%b want pops=2 ne=0", pops - b_pops0, fifo_not_empty);
    end
    $display("test_word_boundary: burst of 6, pops=%0d", pops - b_pops0);
  endtask

  task automatic test_streaming();
    auto_fill = 1'b1;
    repeat (2) @(posedge clk);
    run_burst(8, 0);
    checks++;
    if (b_timeout || got_pix.size() - b_pix0 != 8) begin
      failures++; $display("FAIL stream count got=%0d want=8", got_pix.size() - b_pix0);
    end else begin
      checks++;
      if (acc_cyc[b_acc0 + 7] - acc_cyc[b_acc0] != 7) begin
        failures++; $display("FAIL stream contiguous span got=%0d want=7", acc_cyc[b_acc0 + 7] - acc_cyc[b_acc0]);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_pix[b_pix0 + i] !== exp_pix(b_base, i, 1'b0)) begin
          failures++; $display("FAIL stream pix%0d got=%h want=%h", i, got_pix[b_pix0 + i], exp_pix(b_base, i, 1'b0));
        end
      end
    end
    checks++;
    if (so_cyc.size() - b_so0 != 2) begin
      failures++; $display("FAIL stream shift_outs got=%0d want=2", so_cyc.size() - b_so0);
    end else if (acc_cyc.size() - b_acc0 >= 4) begin
      checks++;
      if (so_cyc[b_so0 + 1] != acc_cyc[b_acc0 + 3]) begin
        failures++; $display("FAIL stream refill cycle got=%0d want=%0d", so_cyc[b_so0 + 1], acc_cyc[b_acc0 + 3]);
      end
    end
    auto_fill = 1'b0;
    flush();
    $display("test_streaming: burst of 8 with full FIFO");
  endtask

  task automatic test_backpressure();
    push(16'($urandom));
    push(16'($urandom));
    run_burst(8, 2);
    checks++;
    if (stall_pix.size() - b_stall0 != 3 || stall_so != b_stall_so0) begin
      failures++; $display("FAIL bp stall cycles got=%0d so=%0d want=3 so=0", stall_pix.size() - b_stall0, stall_so - b_stall_so0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (stall_pix[b_stall0 + i] !== exp_pix(b_base, 2, 1'b0)) begin
          failures++; $display("FAIL bp held pix cycle%0d got=%h want=%h", i, stall_pix[b_stall0 + i], exp_pix(b_base, 2, 1'b0));
        end
      end
    end
    checks++;
    if (b_timeout || got_pix.size() - b_pix0 != 8) begin
      failures++; $display("FAIL bp count got=%0d want=8", got_pix.size() - b_pix0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_pix[b_pix0 + i] !== exp_pix(b_base, i, 1'b0)) begin
          failures++; $display("FAIL bp pix%0d got=%h want=%h", i, got_pix[b_pix0 + i], exp_pix(b_base, i, 1'b0));
        end
      end
    end
    checks++;
    if (pops - b_pops0 != 2) begin failures++; $display("FAIL bp pops got=%0d want=2", pops - b_pops0); end
    $display("test_backpressure: 3 stall cycles after pixel 2");
  endtask

  task automatic test_zero_and_busy_start();
    run_burst(0, 0);
    checks++;
    if (b_timeout || done_cyc[b_done0] != b_start_cyc + 1) begin
      failures++; $display("FAIL zero done cycle got_to=%0d want=1 timeout=%0d", b_timeout ? -1 : done_cyc[b_done0] - b_start_cyc, b_timeout);
    end
    checks++;
    if (so_cyc.size() != b_so0 || busy_cnt != b_busy0) begin
      failures++; $display("FAIL zero side effects got so=%0d busy=%0d want 0 0", so_cyc.size() - b_so0, busy_cnt - b_busy0);
    end
    // start with an empty FIFO, then retrigger while busy: must be ignored
    @(posedge clk); #1;
    snapshot();
    pix_ready = 1'b1;
    start = 1'b1; pix_count = 16'd4;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; pix_count = 16'd3;
    @(posedge clk); #1; start = 1'b0;
    push(16'($urandom));
    b_timeout = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (done_cyc.size() > b_done0) begin b_timeout = 1'b0; break; end
      @(posedge clk); #1;
    end
    push(16'($urandom));
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (b_timeout || got_pix.size() - b_pix0 != 4) begin
      failures++; $display("FAIL busy_start pixels got=%0d want=4", got_pix.size() - b_pix0);
    end
    checks++;
    if (pops - b_pops0 != 1 || done_cyc.size() - b_done0 != 1) begin
      failures++; $display("FAIL busy_start pops=%0d dones=%0d want 1 1", pops - b_pops0, done_cyc.size() - b_done0);
    end
    flush();
    $display("test_zero_and_busy_start: zero burst and ignored restart");
  endtask

  task automatic test_lsb_reset();
    sel = 1'b1;
    push(16'hABCD);
    push(16'h5678);
    @(posedge clk); #1;
    snapshot();
    pix_ready = 1'b1;
    start = 1'b1; pix_count = 16'd4;
    @(posedge clk); #1; start = 1'b0;
    b_timeout = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (got_pix.size() - b_pix0 >= 2) begin b_timeout = 1'b0; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({shift_out_s, pix_valid_s, busy_s, done_s, pix_out_s} !== 8'h00) begin
      failures++; $display("FAIL lsb_reset outputs got=%h want=00", {shift_out_s, pix_valid_s, busy_s, done_s, pix_out_s});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (b_timeout || got_pix[b_pix0] !== 4'hD || got_pix[b_pix0 + 1] !== 4'hC) begin
      failures++; $display("FAIL lsb_order got=%h%h want=DC", got_pix[b_pix0], got_pix[b_pix0 + 1]);
    end
    checks++;
    if (pops - b_pops0 != 1 || fifo_data !== 16'h5678) begin
      failures++; $display("FAIL lsb_reset fifo pops=%0d head=%h want 1 5678", pops - b_pops0, fifo_data);
    end
    run_burst(4, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_timeout || got_pix.size() <= b_pix0 + i || got_pix[b_pix0 + i] !== 4'(8 - i)) begin
        failures++; $display("FAIL lsb_after_reset pix%0d want=%h", i, 4'(8 - i));
      end
    end
    sel = 1'b0;
    $display("test_lsb_reset: reset mid-burst then clean restart");
  endtask

  task automatic test_random();
    int n;
    bit lsb;
    auto_fill = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      lsb = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      sel = lsb;
      n = $urandom_range(1, 13);
      run_burst(n, 1);
      checks++;
      if (b_timeout || got_pix.size() - b_pix0 != n || pops - b_pops0 != (n + 3) / 4) begin
        failures++; $display("FAIL random burst%0d pixels=%0d pops=%0d want %0d %0d", k, got_pix.size() - b_pix0, pops - b_pops0, n, (n + 3) / 4);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_pix[b_pix0 + i] !== exp_pix(b_base, i, lsb)) begin
            failures++; $display("FAIL random burst%0d pix%0d got=%h want=%h", k, i, got_pix[b_pix0 + i], exp_pix(b_base, i, lsb));
          end
        end
      end
      $display("test_random: burst %0d n=%0d lsb=%0d", k, n, lsb);
    end
    auto_fill = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0;
    checks++;
    if (so_viol != 0) begin failures++; $display("FAIL shift_out_on_empty got=%0d want=0", so_viol); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_word_boundary();
    test_streaming();
    test_backpressure();
    test_zero_and_busy_start();
    test_lsb_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
